// File: rtl/gpu_pkg.sv
// gpu_pkg: GPU-wide shared types and default frame geometry
// (used by the framebuffer scanout and the rect execute unit).
package gpu_pkg;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_FETCH = 2'd1,
      SCAN_DRAIN = 2'd2
   } scan_state_e;

   localparam int FRAME_WIDTH_DEFAULT     = 640;
   localparam int FRAME_HEIGHT_DEFAULT    = 480;
   localparam int FBUF_ADDR_WIDTH_DEFAULT = 19;
   localparam int FBUF_DATA_WIDTH_DEFAULT = 8;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// gpu_sync_fifo: single-clock FIFO with wrap-bit pointers; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module gpu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW   = $clog2(DEPTH);
   localparam int PTRW = PW + 1;

   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push_s, do_pop_s;

   always_comb begin
      count     = wr_ptr_q - rd_ptr_q;
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      dout      = mem_q[rd_ptr_q[PW-1:0]];
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      wr_ptr_d  = wr_ptr_q + PTRW'(do_push_s);
      rd_ptr_d  = rd_ptr_q + PTRW'(do_pop_s);
      mem_d     = mem_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q[PW-1:0]] = din;
      end else begin
         mem_d = mem_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/gpu_fbuf_scanout.sv
// gpu_fbuf_scanout: streams one frame from the framebuffer in raster order to a
// valid/ready pixel sink. Define GPU_SCANOUT_SIDEBAND_EN to add pix_sof/pix_eol.
module gpu_fbuf_scanout
   import gpu_pkg::*;
#(
   parameter int FRAME_WIDTH_SCALED  = FRAME_WIDTH_DEFAULT,
   parameter int FRAME_HEIGHT_SCALED = FRAME_HEIGHT_DEFAULT,
   parameter int FBUF_ADDR_WIDTH     = FBUF_ADDR_WIDTH_DEFAULT,
   parameter int FBUF_DATA_WIDTH     = FBUF_DATA_WIDTH_DEFAULT,
   parameter int RD_LATENCY          = 2,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       fbuf_en_rd,
   output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
   input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rdata,
   output logic                       pix_valid,
   input  logic                       pix_ready,
`ifdef GPU_SCANOUT_SIDEBAND_EN
   output logic                       pix_sof,
   output logic                       pix_eol,
`endif
   output logic [FBUF_DATA_WIDTH-1:0] pix_data
);
   localparam int AW  = FBUF_ADDR_WIDTH;
   localparam int DW  = FBUF_DATA_WIDTH;
   localparam int IFW = $clog2(RD_LATENCY + 1);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int OW  = CW + IFW;
`ifdef GPU_SCANOUT_SIDEBAND_EN
   localparam int FW  = DW + 2;
`else
   localparam int FW  = DW;
`endif
   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED - 1);

   if ((longint'(FRAME_WIDTH_SCALED) * FRAME_HEIGHT_SCALED) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_chk_addr
      $error("frame does not fit in FBUF_ADDR_WIDTH");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
      $error("RD_LATENCY must be 1..4");
   end
   if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < RD_LATENCY + 1) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of 2 and at least RD_LATENCY+1");
   end

   scan_state_e           state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [IFW-1:0]        inflight_q, inflight_d;
   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [OW-1:0]         occ_s;
   logic                  issue_s, push_s, pop_s, last_pop_s;
   logic [CW-1:0]         fifo_count_s;
   logic                  fifo_full_s, fifo_empty_s;
   logic [FW-1:0]         fifo_din_s, fifo_dout_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCAN_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN_IDLE:  if (start) state_d = SCAN_FETCH; else state_d = SCAN_IDLE;
         SCAN_FETCH: if (issue_s && addr_q == LAST_ADDR) state_d = SCAN_DRAIN; else state_d = SCAN_FETCH;
         SCAN_DRAIN: if (last_pop_s) state_d = SCAN_IDLE; else state_d = SCAN_DRAIN;
         default:    state_d = SCAN_IDLE;
      endcase
   end

   // Reads in flight count against FIFO space so a returning read always has a slot.
   always_comb begin
      occ_s = OW'(fifo_count_s) + OW'(inflight_q);
      if (state_q == SCAN_FETCH && occ_s < OW'(FIFO_DEPTH) && !fifo_full_s) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      pix_valid = !fifo_empty_s;
      pop_s     = pix_valid && pix_ready;
      if (state_q == SCAN_DRAIN && pop_s && inflight_q == '0 && fifo_count_s == CW'(1)) begin
         last_pop_s = 1'b1;
      end else begin
         last_pop_s = 1'b0;
      end
      done       = last_pop_s;
      busy       = (state_q != SCAN_IDLE);
      fbuf_en_rd = issue_s;
      fbuf_addr  = addr_q;
      pix_data   = fifo_dout_s[DW-1:0];
   end

   always_comb begin
      if (state_q == SCAN_IDLE && start) begin
         addr_d = '0;
      end else if (issue_s) begin
         addr_d = addr_q + AW'(1);
      end else begin
         addr_d = addr_q;
      end
      push_s     = vld_q[RD_LATENCY-1];
      inflight_d = inflight_q + IFW'(issue_s) - IFW'(push_s);
   end

   if (RD_LATENCY == 1) begin : g_pipe1
      always_comb vld_d = issue_s;
   end else begin : g_pipen
      always_comb vld_d = {vld_q[RD_LATENCY-2:0], issue_s};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         inflight_q <= '0;
         vld_q      <= '0;
      end else begin
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         vld_q      <= vld_d;
      end
   end

`ifdef GPU_SCANOUT_SIDEBAND_EN
   localparam int CLW = (FRAME_WIDTH_SCALED > 1) ? $clog2(FRAME_WIDTH_SCALED) : 1;
   localparam logic [CLW-1:0] LAST_COL = CLW'(FRAME_WIDTH_SCALED - 1);

   logic [CLW-1:0] col_q, col_d;
   logic           first_q, first_d;

   // Pushes arrive in address order, so sideband is derived at the FIFO input.
   always_comb begin
      if (state_q == SCAN_IDLE && start) begin
         col_d   = '0;
         first_d = 1'b1;
      end else if (push_s) begin
         col_d   = (col_q == LAST_COL) ? '0 : col_q + CLW'(1);
         first_d = 1'b0;
      end else begin
         col_d   = col_q;
         first_d = first_q;
      end
      fifo_din_s = {first_q, (col_q == LAST_COL), fbuf_rdata};
      pix_sof    = fifo_dout_s[FW-1] && !fifo_empty_s;
      pix_eol    = fifo_dout_s[FW-2] && !fifo_empty_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q   <= '0;
         first_q <= 1'b0;
      end else begin
         col_q   <= col_d;
         first_q <= first_d;
      end
   end
`else
   always_comb fifo_din_s = fbuf_rdata;
`endif

   gpu_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

endmodule

// File: tb/tb_gpu_fbuf_scanout.sv
// tb_gpu_fbuf_scanout: 8x2 frame, latency-2 memory returning addr[7:0];
// per-cycle reference model plus a table of frame scenarios.
module tb_gpu_fbuf_scanout;
   localparam int W  = 8;
   localparam int H  = 2;
   localparam int N  = W * H;
   localparam int L  = 2;
   localparam int D  = 4;
   localparam int AW = 19;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, start, busy, done, fbuf_en_rd, pix_valid, pix_ready;
   logic [AW-1:0] fbuf_addr;
   logic [DW-1:0] fbuf_rdata, pix_data;
`ifdef GPU_SCANOUT_SIDEBAND_EN
   logic          pix_sof, pix_eol;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gpu_fbuf_scanout #(
      .FRAME_WIDTH_SCALED  (W),
      .FRAME_HEIGHT_SCALED (H),
      .FBUF_ADDR_WIDTH     (AW),
      .FBUF_DATA_WIDTH     (DW),
      .RD_LATENCY          (L),
      .FIFO_DEPTH          (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fbuf_en_rd (fbuf_en_rd),
      .fbuf_addr  (fbuf_addr),
      .fbuf_rdata (fbuf_rdata),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
`ifdef GPU_SCANOUT_SIDEBAND_EN
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
`endif
      .pix_data   (pix_data)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: data for a read is presented exactly L cycles later, junk otherwise.
   bit [DW-1:0] mp_a [L];
   bit          mp_v [L];
   bit [DW-1:0] junk;
   always @(posedge clk) begin
      mp_v[0] <= fbuf_en_rd;
      mp_a[0] <= fbuf_addr[DW-1:0];
      for (int i = 1; i < L; i++) begin
         mp_v[i] <= mp_v[i-1];
         mp_a[i] <= mp_a[i-1];
      end
      junk <= DW'($urandom);
   end
   assign fbuf_rdata = mp_v[L-1] ? mp_a[L-1] : junk;

   // Reference model: counts of reads issued and pixels accepted in the current frame.
   bit          m_busy, prev_stall;
   int          m_iss, m_acc;
   logic [DW-1:0] prev_data;
   int          hs_cnt = 0, done_cnt = 0, iss_cnt = 0;

   always @(negedge clk) begin
      bit hs, exp_done, exp_en;
      if (rst) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_en_rd", fbuf_en_rd, 0);
         chk("rst_addr", fbuf_addr, 0);
         chk("rst_valid", pix_valid, 0);
         chk("rst_data", pix_data, 0);
         m_busy = 1'b0; m_iss = 0; m_acc = 0; prev_stall = 1'b0;
      end else begin
         hs     = pix_valid && pix_ready;
         exp_en = m_busy && (m_iss < N) && ((m_iss - m_acc) < D);
         chk("busy", busy, m_busy);
         chk("fbuf_en_rd", fbuf_en_rd, exp_en);
         if (fbuf_en_rd) begin
            chk("fbuf_addr", fbuf_addr, m_iss);
            m_iss++;
            iss_cnt++;
         end
         if (prev_stall) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, prev_data);
         end
         exp_done = hs && m_busy && (m_acc == N - 1);
         chk("done", done, exp_done);
         if (hs) begin
            chk("pix_data", pix_data, m_acc % 256);
`ifdef GPU_SCANOUT_SIDEBAND_EN
            chk("pix_sof", pix_sof, (m_acc == 0));
            chk("pix_eol", pix_eol, ((m_acc % W) == W - 1));
`endif
            m_acc++;
            hs_cnt++;
         end
         if (done) done_cnt++;
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
         if (exp_done) begin
            m_busy = 1'b0;
         end else if (!m_busy && start) begin
            m_busy = 1'b1; m_iss = 0; m_acc = 0;
         end
      end
   end

   typedef struct {
      logic [15:0] ready_pat;
      bit          rand_ready;
      int          restart_at;
      int          exp_pix;
      int          exp_done;
   } vec_t;

   task automatic run_frame(input vec_t v, output int npix, output int ndone);
      int h0, d0, cyc;
      h0 = hs_cnt;
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (done_cnt == d0 && cyc < 400) begin
         pix_ready = v.rand_ready ? 1'($urandom) : v.ready_pat[cyc % 16];
         start     = (cyc == v.restart_at);
         tick();
         cyc++;
      end
      start     = 1'b0;
      pix_ready = 1'b1;
      repeat (4) tick();
      npix  = hs_cnt - h0;
      ndone = done_cnt - d0;
   endtask

   vec_t vecs[6];
   int   n, c, i0, h0, d0, npix, ndone;

   initial begin
      vecs[0] = '{16'hFFFF, 1'b0, -1, N, 1};
      vecs[1] = '{16'h5555, 1'b0, -1, N, 1};
      vecs[2] = '{16'h0000, 1'b1, -1, N, 1};
      vecs[3] = '{16'hFFFF, 1'b0,  6, N, 1};
      vecs[4] = '{16'h3C3C, 1'b0, 12, N, 1};
      vecs[5] = '{16'h0000, 1'b1,  3, N, 1};

      rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // First pixel latency and full-rate streaming.
      pix_ready = 1'b1;
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!pix_valid && n < 20) begin tick(); n++; end
      chk("first_valid_latency", n, L + 1);
      c = 1;
      while (!done && c < 200) begin tick(); c++; end
      chk("frame_cycles", c, N);
      repeat (3) tick();
      chk("idle_busy", busy, 0);
      chk("single_done", done_cnt - d0, 1);

      for (int k = 0; k < 6; k++) begin
         run_frame(vecs[k], npix, ndone);
         chk($sformatf("vec%0d_pixels", k), npix, vecs[k].exp_pix);
         chk($sformatf("vec%0d_dones", k), ndone, vecs[k].exp_done);
         chk($sformatf("vec%0d_busy", k), busy, 0);
      end

      // Sink stalled: reads stop at FIFO_DEPTH and the head holds pixel 0.
      pix_ready = 1'b0;
      i0 = iss_cnt; h0 = hs_cnt; d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      chk("stalled_reads", iss_cnt - i0, D);
      chk("stalled_valid", pix_valid, 1);
      chk("stalled_data", pix_data, 0);
      pix_ready = 1'b1;
      c = 0;
      while (done_cnt == d0 && c < 200) begin tick(); c++; end
      tick();
      chk("stalled_pixels", hs_cnt - h0, N);

      // Reset mid-frame at pixel 5, one-cycle pulse while reads are still returning.
      h0 = hs_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while ((hs_cnt - h0) < 5 && c < 100) begin tick(); c++; end
      chk("reached_pixel5", hs_cnt - h0, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_valid", pix_valid, 0);
      chk("post_rst_busy", busy, 0);
      run_frame(vecs[0], npix, ndone);
      chk("restart_pixels", npix, N);
      chk("restart_dones", ndone, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpu_fbuf_scanout.md
GPU_FBUF_SCANOUT -- requirements
Module: gpu_fbuf_scanout

Interface
REQ-001 SHALL have parameter FRAME_WIDTH_SCALED, default 640, pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT_SCALED, default 480, lines per frame.
REQ-003 SHALL have parameter FBUF_ADDR_WIDTH, default 19, framebuffer address width.
REQ-004 SHALL have parameter FBUF_DATA_WIDTH, default 8, pixel width.
REQ-005 SHALL have parameter RD_LATENCY, default 2, framebuffer read latency in cycles (1..4).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, at least RD_LATENCY+1).
REQ-007 clk  in  1  single clock; all logic is rising-edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 start  in  1  single-cycle request to scan one frame.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  single-cycle pulse after the last pixel is accepted.
REQ-012 fbuf_en_rd  out  1  framebuffer read enable.
REQ-013 fbuf_addr  out  FBUF_ADDR_WIDTH  framebuffer read address.
REQ-014 fbuf_rdata  in  FBUF_DATA_WIDTH  read data, valid RD_LATENCY cycles after fbuf_en_rd.
REQ-015 pix_valid  out  1  output pixel valid.
REQ-016 pix_ready  in  1  sink ready.
REQ-017 pix_data  out  FBUF_DATA_WIDTH  pixel value.

Function
REQ-018 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-019 In IDLE, start=1 SHALL move the block to FETCH on the next cycle, clear the address and set busy.
REQ-020 start while busy SHALL be ignored.
REQ-021 In FETCH, fbuf_en_rd SHALL assert whenever (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-022 The address SHALL increment by 1 per issued read, covering 0 .. W*H-1 in raster order.
REQ-023 Read data SHALL be captured into the FIFO exactly RD_LATENCY cycles after each issued read, using a valid shift register of length RD_LATENCY.
REQ-024 The FIFO SHALL never overflow.
REQ-025 Issuing read W*H-1 SHALL move the block to DRAIN.
REQ-026 In DRAIN, the block SHALL transition to IDLE when the last pixel handshake (pix_valid & pix_ready) completes, pulse done for 1 cycle in that same cycle, and drop busy the following cycle.
REQ-027 pix_valid SHALL equal FIFO non-empty.
REQ-028 pix_data SHALL be the FIFO head.
REQ-029 pix_data SHALL be stable while pix_valid=1 and pix_ready=0.
REQ-030 A simultaneous FIFO push and pop SHALL keep occupancy unchanged; pushing into a full FIFO with a pop in the same cycle SHALL be legal.
REQ-031 The in-flight counter SHALL be wide enough for RD_LATENCY; the address counter SHALL be FBUF_ADDR_WIDTH bits, and W*H SHALL fit within it (elaboration check).
REQ-032 With continuous pix_ready=1, steady-state throughput SHALL be 1 pixel/cycle, and the first pix_valid SHALL appear RD_LATENCY+1 cycles after start.

Reset
REQ-033 rst SHALL force IDLE and set busy=0, done=0, fbuf_en_rd=0, fbuf_addr=0, pix_valid=0, pix_data=0, and clear the FIFO pointers, in-flight counter and latency pipe.
REQ-034 Reset mid-frame SHALL discard all buffered and in-flight data; read data returning after reset SHALL be ignored.

Configuration
REQ-035 The macro GPU_SCANOUT_SIDEBAND_EN, when defined, SHALL add outputs pix_sof (1 bit, high with the pixel at address 0) and pix_eol (1 bit, high with the last pixel of each line), carried through the FIFO alongside the data.
REQ-036 When GPU_SCANOUT_SIDEBAND_EN is undefined, those ports and their storage SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 Package gpu_pkg SHALL hold the scanout state enum and the default frame-geometry constants shared with the rect execute unit.
REQ-038 The FIFO SHALL be a separate sub-module gpu_sync_fifo (parameters depth/width; signals push, pop, full, empty, count).

Verification
REQ-039 W=8, H=2, memory model with fbuf_rdata = addr[7:0], pix_ready held 1, start pulse -> 16 pixels 0..15 on consecutive cycles, then done pulsed once, busy low after.
REQ-040 Same setup with pix_ready toggling 1-0-1-0 -> same 0..15 sequence, no loss or duplication, pix_data stable during stalls, fbuf_en_rd throttled.
REQ-041 pix_ready=0 for 20 cycles after start -> exactly FIFO_DEPTH reads issued, pix_data=0 held; releasing ready resumes the sequence correctly.
REQ-042 rst asserted at pixel 5, then a new start -> stream restarts at 0 with no stale data.
REQ-043 start re-pulsed mid-frame -> ignored, only one done; with GPU_SCANOUT_SIDEBAND_EN defined -> pix_sof on pixel 0 and pix_eol on pixels 7 and 15.
